priority_arbiter_16: RTL and testbench
======================================

PRIORITY_ARBITER_16 -- requirements
Module: priority_arbiter_16

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 8, maximum consecutive cycles one grant may be held (legal range 2..255).
REQ-002 SHALL have port: clk_dut  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset_dut  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: enable_dut  input  1  permits new grants when high.
REQ-005 SHALL have port: req_dut  input  16  request vector; bit i is requester i.
REQ-006 SHALL have port: grant_vec_dut  output  16  one-hot grant, registered.
REQ-007 SHALL have port: grant_id_dut  output  4  index of granted requester, 0-based, registered.
REQ-008 SHALL have port: grant_valid_dut  output  1  high while any grant is active.
REQ-009 SHALL have port: timeout_dut  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and RELEASE.
REQ-011 IDLE: if enable_dut=1 and req_dut!=0 at an edge, the arbiter SHALL select a winner, load the grant outputs, clear the hold counter and enter BUSY at that edge; grant is visible one cycle after the request is sampled.
REQ-012 IDLE with enable_dut=0 or req_dut=0 SHALL remain in IDLE with no grant.
REQ-013 BUSY: the hold counter SHALL increment each cycle; enable_dut SHALL NOT affect an active grant.
REQ-014 BUSY, req_dut[grant_id_dut]=0 at an edge: grant SHALL drop at that edge, state -> RELEASE, timeout_dut stays 0.
REQ-015 BUSY, request still high when counter = MAX_HOLD-1: grant SHALL drop at that edge, timeout_dut=1 for exactly one cycle, state -> RELEASE.
REQ-016 A grant SHALL therefore last at most MAX_HOLD cycles.
REQ-017 RELEASE SHALL last exactly one cycle with no grant (bus turnaround), then go to IDLE; new arbitration first occurs at the IDLE edge.
REQ-018 grant_vec_dut SHALL always be one-hot or zero; grant_valid_dut = |grant_vec_dut; grant_id_dut SHALL be 0 when no grant.
REQ-019 Requests arriving or changing on non-granted bits during BUSY/RELEASE SHALL be ignored until the next IDLE arbitration.
REQ-020 A timed-out requester that keeps its request high SHALL be eligible again at the next arbitration under the active priority rule.

Reset
REQ-021 reset_dut=1 SHALL immediately, independent of clk_dut, force state IDLE, grant_vec_dut=0, grant_id_dut=0, grant_valid_dut=0, timeout_dut=0, hold counter 0, round-robin pointer 0.
REQ-022 Reset asserted mid-grant SHALL abort the grant without a timeout pulse; the first arbitration after release SHALL occur at the first rising edge with reset_dut=0.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN defined: winner SHALL be the first requesting bit at or above the pointer, wrapping 15->0; pointer SHALL be updated to (winner+1) mod 16 on each grant.
REQ-024 Macro ARB_ROUND_ROBIN_EN undefined: winner SHALL be the lowest-index requesting bit (fixed priority, bit 0 highest); no pointer register SHALL exist.

Verification
REQ-025 req=0x0005, enable=1 from reset -> grant_id=0, grant_vec=0x0001 one cycle later; req[0] drops after 3 cycles -> one RELEASE cycle, then grant_id=2.
REQ-026 req=0x8000 held, MAX_HOLD=8 -> grant lasts 8 cycles, timeout_dut pulses once, 1 idle cycle, re-grant to id 15.
REQ-027 ARB_ROUND_ROBIN_EN, req=0xFFFF held with 1-cycle grants -> grant_id sequence 0,1,2,...,15,0 (wrap-around); without macro -> always 0.
REQ-028 enable=0, req=0x0100 -> no grant; enable deasserted during an active grant -> grant continues until release or timeout.
REQ-029 reset_dut asserted between clock edges during BUSY -> all outputs 0 before the next edge; after release, req=0x0010 -> grant_id=4 with pointer restarted at 0.

Source files
------------

// File: rtl/priority_arbiter_16.sv
// 16-way arbiter with bounded grant hold (MAX_HOLD) and a one-cycle turnaround after each grant.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority (bit 0 highest).
module priority_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk_dut,
    input  logic        reset_dut,
    input  logic        enable_dut,
    input  logic [15:0] req_dut,
    output logic [15:0] grant_vec_dut,
    output logic [3:0]  grant_id_dut,
    output logic        grant_valid_dut,
    output logic        timeout_dut
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      r_state;
    logic [7:0]  r_hold_cnt;
    logic [15:0] r_grant_vec;
    logic [3:0]  r_grant_id;
    logic        r_grant_valid;
    logic        r_timeout;
    logic [3:0]  w_winner;
    logic        w_any_req;

    assign w_any_req = |req_dut;

`ifdef ARB_ROUND_ROBIN_EN
    logic [3:0] r_ptr;
    logic [3:0] w_scan_idx;
    logic       w_found;

    // Winner select: first requester at or above the pointer, wrapping 15 -> 0.
    always_comb begin
        w_winner   = 4'd0;
        w_found    = 1'b0;
        w_scan_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_scan_idx = r_ptr + 4'(i);
            if (!w_found && req_dut[w_scan_idx]) begin
                w_winner = w_scan_idx;
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Rotating pointer advances past each new winner.
    always_ff @(posedge clk_dut or posedge reset_dut) begin
        if (reset_dut) begin
            r_ptr <= 4'd0;
        end else if (r_state == ST_IDLE && enable_dut && w_any_req) begin
            r_ptr <= w_winner + 4'd1;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    // Winner select: lowest-index requester wins (scan from the top so bit 0 ends last).
    always_comb begin
        w_winner = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_dut[i]) begin
                w_winner = 4'(i);
            end else begin
                w_winner = w_winner;
            end
        end
    end
`endif

    // Arbitration FSM with registered grant and timeout outputs.
    always_ff @(posedge clk_dut or posedge reset_dut) begin
        if (reset_dut) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= 8'd0;
            r_grant_vec   <= 16'd0;
            r_grant_id    <= 4'd0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout  <= 1'b0;
                    r_hold_cnt <= 8'd0;
                    if (enable_dut && w_any_req) begin
                        r_grant_vec   <= 16'd1 << w_winner;
                        r_grant_id    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_BUSY;
                    end else begin
                        r_grant_vec   <= 16'd0;
                        r_grant_id    <= 4'd0;
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // enable_dut is deliberately ignored while a grant is held.
                    if (!req_dut[r_grant_id]) begin
                        r_grant_vec   <= 16'd0;
                        r_grant_id    <= 4'd0;
                        r_grant_valid <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_hold_cnt    <= 8'd0;
                        r_state       <= ST_RELEASE;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_grant_vec   <= 16'd0;
                        r_grant_id    <= 4'd0;
                        r_grant_valid <= 1'b0;
                        r_timeout     <= 1'b1;
                        r_hold_cnt    <= 8'd0;
                        r_state       <= ST_RELEASE;
                    end else begin
                        r_timeout     <= 1'b0;
                        r_hold_cnt    <= r_hold_cnt + 8'd1;
                        r_state       <= ST_BUSY;
                    end
                end
                ST_RELEASE: begin
                    r_grant_vec   <= 16'd0;
                    r_grant_id    <= 4'd0;
                    r_grant_valid <= 1'b0;
                    r_timeout     <= 1'b0;
                    r_hold_cnt    <= 8'd0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_grant_vec   <= 16'd0;
                    r_grant_id    <= 4'd0;
                    r_grant_valid <= 1'b0;
                    r_timeout     <= 1'b0;
                    r_hold_cnt    <= 8'd0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_vec_dut   = r_grant_vec;
    assign grant_id_dut    = r_grant_id;
    assign grant_valid_dut = r_grant_valid;
    assign timeout_dut     = r_timeout;

endmodule

// File: tb/tb_priority_arbiter_16.sv
// Directed self-checking bench for priority_arbiter_16 (MAX_HOLD = 8).
module tb_priority_arbiter_16;

    logic        clk_dut;
    logic        reset_dut;
    logic        enable_dut;
    logic [15:0] req_dut;
    logic [15:0] grant_vec_dut;
    logic [3:0]  grant_id_dut;
    logic        grant_valid_dut;
    logic        timeout_dut;

    int total;
    int bad;

    priority_arbiter_16 #(.MAX_HOLD(8)) dut (
        .clk_dut         (clk_dut),
        .reset_dut       (reset_dut),
        .enable_dut      (enable_dut),
        .req_dut         (req_dut),
        .grant_vec_dut   (grant_vec_dut),
        .grant_id_dut    (grant_id_dut),
        .grant_valid_dut (grant_valid_dut),
        .timeout_dut     (timeout_dut)
    );

    initial clk_dut = 1'b0;
    always #5 clk_dut = ~clk_dut;

    task automatic tick();
        @(posedge clk_dut);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [15:0] vec, input logic [3:0] id,
                             input logic valid, input logic tmo);
        chk({tag, ".vec"},   32'(grant_vec_dut),   32'(vec));
        chk({tag, ".id"},    32'(grant_id_dut),    32'(id));
        chk({tag, ".valid"}, 32'(grant_valid_dut), 32'(valid));
        chk({tag, ".tmo"},   32'(timeout_dut),     32'(tmo));
    endtask

    initial begin
        logic [3:0] exp_id;
        total      = 0;
        bad        = 0;
        reset_dut  = 1'b1;
        enable_dut = 1'b0;
        req_dut    = 16'h0000;
        #1;
        chk_grant("reset_async", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset_dut = 1'b0;

        // Two requesters: bit 0 wins, holds 3 cycles, then turnaround and bit 2.
        req_dut    = 16'h0005;
        enable_dut = 1'b1;
        tick();
        chk_grant("t025_first", 16'h0001, 4'd0, 1'b1, 1'b0);
        tick();
        chk_grant("t025_hold2", 16'h0001, 4'd0, 1'b1, 1'b0);
        tick();
        chk_grant("t025_hold3", 16'h0001, 4'd0, 1'b1, 1'b0);
        req_dut = 16'h0004;
        tick();
        chk_grant("t025_release", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_grant("t025_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_grant("t025_second", 16'h0004, 4'd2, 1'b1, 1'b0);
        req_dut = 16'h0000;
        tick();
        chk_grant("t025_drop", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_grant("idle_noreq", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Held request on bit 15 is revoked after 8 cycles, then re-granted.
        req_dut = 16'h8000;
        tick();
        chk_grant("t026_c1", 16'h8000, 4'd15, 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk_grant($sformatf("t026_c%0d", c), 16'h8000, 4'd15, 1'b1, 1'b0);
        end
        tick();
        chk_grant("t026_timeout", 16'h0000, 4'd0, 1'b0, 1'b1);
        tick();
        chk_grant("t026_tmo_once", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_grant("t026_regrant", 16'h8000, 4'd15, 1'b1, 1'b0);
        req_dut = 16'h0000;
        tick();
        chk_grant("t026_drop", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();

        // Enable gates new grants only; other requests are ignored while busy.
        enable_dut = 1'b0;
        req_dut    = 16'h0100;
        tick();
        chk_grant("t028_dis1", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_grant("t028_dis2", 16'h0000, 4'd0, 1'b0, 1'b0);
        enable_dut = 1'b1;
        tick();
        chk_grant("t028_grant", 16'h0100, 4'd8, 1'b1, 1'b0);
        enable_dut = 1'b0;
        req_dut    = 16'h0101;
        tick();
        chk_grant("t028_keep1", 16'h0100, 4'd8, 1'b1, 1'b0);
        tick();
        chk_grant("t028_keep2", 16'h0100, 4'd8, 1'b1, 1'b0);
        req_dut = 16'h0000;
        tick();
        chk_grant("t028_release", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();

        // Reset between edges during a grant clears outputs immediately.
        enable_dut = 1'b1;
        req_dut    = 16'h0040;
        tick();
        chk_grant("t029_busy", 16'h0040, 4'd6, 1'b1, 1'b0);
        #2;
        reset_dut = 1'b1;
        #1;
        chk_grant("t029_async", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_grant("t029_inreset", 16'h0000, 4'd0, 1'b0, 1'b0);
        reset_dut = 1'b0;
        req_dut   = 16'h0010;
        tick();
        chk_grant("t029_after", 16'h0010, 4'd4, 1'b1, 1'b0);
        req_dut = 16'h0000;
        tick();
        tick();

        // All requesting with one-cycle grants; reset first so the pointer starts at 0.
        reset_dut = 1'b1;
        tick();
        reset_dut = 1'b0;
        for (int k = 0; k < 17; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_id = 4'(k % 16);
`else
            exp_id = 4'd0;
`endif
            req_dut = 16'hFFFF;
            tick();
            chk_grant($sformatf("t027_k%0d", k), 16'd1 << exp_id, exp_id, 1'b1, 1'b0);
            req_dut = 16'hFFFF & ~(16'd1 << exp_id);
            tick();
            chk({"t027_rel", $sformatf("%0d", k)}, 32'(grant_valid_dut), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
